// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter that shares one BRAM bank among PARALLEL requesters and
// routes read data back to the issuing requester through a tagged latency pipeline.
module bank_rr_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int PARALLEL   = 16,
  parameter int LOWER_ADDR = 0,
  parameter int UPPER_ADDR = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PARALLEL-1:0]              req,
  input  logic [PARALLEL-1:0]              write_en,
  input  logic [ADDR_WIDTH*PARALLEL-1:0]   addrFM,
  input  logic [DATA_WIDTH*PARALLEL-1:0]   dataFM,
  output logic [PARALLEL-1:0]              gnt,
  output logic [PARALLEL-1:0]              conflict,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            data_mem,
  output logic [DATA_WIDTH*PARALLEL-1:0]   dataM,
  output logic [PARALLEL-1:0]              rvalid
);

  localparam int                     PW       = $clog2(PARALLEL);
  localparam logic [ADDR_WIDTH-1:0]  LOWER_A  = ADDR_WIDTH'(LOWER_ADDR);
  localparam logic [PW-1:0]          LAST_IDX = PW'(PARALLEL - 1);
  localparam logic [PW-1:0]          ONE_PW   = PW'(1'b1);
  localparam logic [PARALLEL-1:0]    ONE_P    = PARALLEL'(1'b1);

  logic [PARALLEL-1:0]   gnt_r;
  logic [PARALLEL-1:0]   conflict_r;
  logic [PARALLEL-1:0]   rvalid_r;
  logic                  mem_en_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [PW-1:0]         ptr_r;
  logic [PW-1:0]         gnt_idx_r;
  logic                  rd_vld_r [RD_LATENCY];
  logic [PW-1:0]         rd_tag_r [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_r    [PARALLEL];

  logic [ADDR_WIDTH-1:0] addr_s   [PARALLEL];
  logic [DATA_WIDTH-1:0] wdat_s   [PARALLEL];
  logic [PARALLEL-1:0]   in_win_s;
  logic [PARALLEL-1:0]   elig_s;
  logic [PARALLEL-1:0]   win_oh_s;
  logic                  found_s;
  logic [PW-1:0]         win_s;
  logic [PW-1:0]         ptr_next_s;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    int av;
    av = int'(a);
    return (av >= LOWER_ADDR) && (av <= UPPER_ADDR);
  endfunction

  for (genvar g = 0; g < PARALLEL; g++) begin : g_slot
    assign addr_s[g]   = addrFM[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_s[g]   = dataFM[g*DATA_WIDTH +: DATA_WIDTH];
    assign in_win_s[g] = in_window(addr_s[g]);
    assign dataM[g*DATA_WIDTH +: DATA_WIDTH] = dat_r[g];
  end

  // Last cycle's winner is masked so a held request cannot take two slots in a row.
  assign elig_s = req & in_win_s & ~gnt_r;

  // Pick the first eligible requester at or after the pointer, wrapping around.
  always_comb begin
    int idx_v;
    idx_v   = 0;
    win_s   = '0;
    for (int k = PARALLEL - 1; k >= 0; k--) begin
      idx_v = int'(ptr_r) + k;
      idx_v = (idx_v >= PARALLEL) ? (idx_v - PARALLEL) : idx_v;
      win_s = elig_s[PW'(idx_v)] ? PW'(idx_v) : win_s;
    end
    found_s    = |elig_s;
    win_oh_s   = found_s ? (ONE_P << win_s) : '0;
    ptr_next_s = (win_s == LAST_IDX) ? '0 : (win_s + ONE_PW);
  end

  // Register the grant decision and drive the BRAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= '0;
      conflict_r  <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ptr_r       <= '0;
      gnt_idx_r   <= '0;
    end else if (found_s) begin
      gnt_r       <= win_oh_s;
      conflict_r  <= elig_s & ~win_oh_s;
      mem_en_r    <= 1'b1;
      mem_we_r    <= write_en[win_s];
      mem_addr_r  <= addr_s[win_s] - LOWER_A;
      mem_wdata_r <= wdat_s[win_s];
      ptr_r       <= ptr_next_s;
      gnt_idx_r   <= win_s;
    end else begin
      gnt_r       <= '0;
      conflict_r  <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
    end
  end

  // Carry each issued read's requester index until the BRAM data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        rd_vld_r[s] <= 1'b0;
        rd_tag_r[s] <= '0;
      end
    end else begin
      rd_vld_r[0] <= mem_en_r & ~mem_we_r;
      rd_tag_r[0] <= gnt_idx_r;
      for (int s = 1; s < RD_LATENCY; s++) begin
        rd_vld_r[s] <= rd_vld_r[s-1];
        rd_tag_r[s] <= rd_tag_r[s-1];
      end
    end
  end

  // Latch returning read data into the issuer's slot and pulse its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_r <= '0;
      for (int p = 0; p < PARALLEL; p++) begin
        dat_r[p] <= '0;
      end
    end else begin
      rvalid_r <= rd_vld_r[RD_LATENCY-1] ? (ONE_P << rd_tag_r[RD_LATENCY-1]) : '0;
      for (int p = 0; p < PARALLEL; p++) begin
        if (rd_vld_r[RD_LATENCY-1] && (rd_tag_r[RD_LATENCY-1] == PW'(p))) begin
          dat_r[p] <= data_mem;
        end else begin
          dat_r[p] <= dat_r[p];
        end
      end
    end
  end

  assign gnt       = gnt_r;
  assign conflict  = conflict_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rvalid    = rvalid_r;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Bench for bank_rr_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level scoreboard built from the arbitration and read-return rules.
module tb_bank_rr_arbiter;

  localparam int P = 16, AW = 13, DW = 32, LO = 4, HI = 7, L = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [P-1:0]  req = '0;
  logic [P-1:0]  write_en = '0;
  logic [AW*P-1:0] addrFM;
  logic [DW*P-1:0] dataFM;
  logic [DW-1:0] data_mem = '0;
  logic [P-1:0]  gnt, conflict, rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW*P-1:0] dataM;

  int            a_addr [P];
  logic [DW-1:0] a_data [P];

  always #5 clk = ~clk;

  always_comb begin
    addrFM = '0;
    dataFM = '0;
    for (int i = 0; i < P; i++) begin
      addrFM[i*AW +: AW] = AW'(a_addr[i]);
      dataFM[i*DW +: DW] = a_data[i];
    end
  end

  bank_rr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLEL(P),
    .LOWER_ADDR(LO), .UPPER_ADDR(HI), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .write_en(write_en),
    .addrFM(addrFM), .dataFM(dataFM), .gnt(gnt), .conflict(conflict),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .data_mem(data_mem), .dataM(dataM), .rvalid(rvalid)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Reference state: what the outputs should show in the current cycle.
  int            m_gnt, m_ptr;
  logic [P-1:0]  m_gv, m_conf, m_rv;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_dat [P];
  int            rd_tag_q[$];
  int            rd_due_q[$];
  bit            dm_fix = 1'b0;
  logic [DW-1:0] dm_word = '0;

  function automatic bit in_win(int a);
    return (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [DW*P-1:0] exp_dm();
    logic [DW*P-1:0] v;
    v = '0;
    for (int i = 0; i < P; i++) v[i*DW +: DW] = m_dat[i];
    return v;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_ptr = 0; m_gv = '0; m_conf = '0; m_rv = '0;
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < P; i++) m_dat[i] = '0;
    rd_tag_q.delete();
    rd_due_q.delete();
  endtask

  task automatic model_step();
    int w;
    logic [P-1:0] elig;
    m_rv = '0;
    if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
      m_dat[rd_tag_q[0]] = data_mem;
      m_rv[rd_tag_q[0]] = 1'b1;
      void'(rd_tag_q.pop_front());
      void'(rd_due_q.pop_front());
    end
    elig = '0;
    for (int i = 0; i < P; i++) elig[i] = req[i] && in_win(a_addr[i]) && (i != m_gnt);
    w = -1;
    for (int k = 0; k < P; k++) if (w < 0 && elig[(m_ptr + k) % P]) w = (m_ptr + k) % P;
    cyc++;
    if (w >= 0) begin
      m_gnt = w; m_gv = '0; m_gv[w] = 1'b1;
      m_conf = elig; m_conf[w] = 1'b0;
      m_en = 1'b1; m_we = write_en[w];
      m_addr = AW'(a_addr[w] - LO); m_wdata = a_data[w];
      m_ptr = (w + 1) % P;
      if (!write_en[w]) begin
        rd_tag_q.push_back(w);
        rd_due_q.push_back(cyc + L);
      end
    end else begin
      m_gnt = -1; m_gv = '0; m_conf = '0; m_en = 1'b0; m_we = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    data_mem = dm_fix ? dm_word : $urandom();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_tests++;
    if ({gnt, conflict, rvalid, mem_en, mem_we, mem_addr, mem_wdata, dataM} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got gnt=%h conf=%h rv=%h en=%b we=%b addr=%h wd=%h exp all 0",
               gnt, conflict, rvalid, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1; model_reset(); cyc = 0;
    a_addr[0] = LO; a_addr[1] = LO + 1; req = 16'h0003;
    step(); req[0] = 1'b0;
    step(); req[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, conflict, rvalid, mem_en, mem_we, mem_addr, mem_wdata, dataM} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream got gnt=%h conf=%h rv=%h en=%b addr=%h exp all 0",
               gnt, conflict, rvalid, mem_en, mem_addr);
    end
    repeat (2) @(posedge clk);
    #3;
    req = '0; rst_n = 1'b1; model_reset();
    for (int k = 0; k < L + 4; k++) begin
      step();
      n_tests++;
      if (rvalid !== '0 || dataM !== '0) begin
        n_fail++;
        $display("FAIL reset_no_rvalid cycle %0d got rv=%h exp 0", k, rvalid);
      end
    end
  endtask

  task automatic test_single_read();
    int lat, pulses;
    logic [P-1:0] rv_seen;
    a_addr[3] = LO + 2; write_en = '0; req = 16'h0008;
    dm_fix = 1'b1; dm_word = 32'hA5A5_0003;
    step();
    n_tests++;
    if (gnt !== 16'h0008 || mem_addr !== 13'd2 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant got gnt=%h addr=%h en=%b we=%b exp gnt=0008 addr=0002 en=1 we=0",
               gnt, mem_addr, mem_en, mem_we);
    end
    req = '0; lat = 0; pulses = 0; rv_seen = '0;
    for (int k = 1; k <= L + 4; k++) begin
      step();
      if (rvalid !== '0) begin
        pulses++;
        if (lat == 0) begin lat = k; rv_seen = rvalid; end
      end
    end
    n_tests++;
    if (lat != L + 1 || pulses != 1 || rv_seen !== 16'h0008) begin
      n_fail++;
      $display("FAIL single_latency got lat=%0d pulses=%0d rv=%h exp lat=%0d pulses=1 rv=0008",
               lat, pulses, rv_seen, L + 1);
    end
    n_tests++;
    if (dataM[3*DW +: DW] !== 32'hA5A5_0003) begin
      n_fail++;
      $display("FAIL single_data got %h exp a5a50003", dataM[3*DW +: DW]);
    end
    dm_fix = 1'b0;
  endtask

  task automatic test_round_robin();
    int start, ew;
    logic [P-1:0] eoh, prev_oh, econf;
    for (int i = 0; i < P; i++) begin a_addr[i] = LO + 1; a_data[i] = $urandom(); end
    write_en = '0; req = '1;
    start = m_ptr; prev_oh = m_gv;
    for (int k = 0; k <= P; k++) begin
      step();
      ew = (start + k) % P;
      eoh = '0; eoh[ew] = 1'b1;
      econf = ~eoh & ~prev_oh;
      n_tests++;
      if (gnt !== eoh || conflict !== econf) begin
        n_fail++;
        $display("FAIL rr_order step %0d got gnt=%h conf=%h exp gnt=%h conf=%h", k, gnt, conflict, eoh, econf);
      end
      n_tests++;
      if (rvalid !== m_rv || dataM !== exp_dm()) begin
        n_fail++;
        $display("FAIL rr_return step %0d got rv=%h exp rv=%h", k, rvalid, m_rv);
      end
      prev_oh = eoh;
    end
    req = '0;
    repeat (L + 3) step();
  endtask

  task automatic test_window();
    a_addr[0] = LO - 1; a_addr[1] = HI + 1; a_addr[2] = HI; write_en = '0; req = 16'h0007;
    step();
    n_tests++;
    if (gnt !== 16'h0004 || mem_addr !== 13'd3 || conflict !== '0) begin
      n_fail++;
      $display("FAIL window_grant got gnt=%h addr=%h conf=%h exp gnt=0004 addr=0003 conf=0000",
               gnt, mem_addr, conflict);
    end
    req[2] = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      step();
      n_tests++;
      if (gnt !== '0 || conflict !== '0 || mem_en !== 1'b0 || mem_addr !== 13'd3 || rvalid !== m_rv) begin
        n_fail++;
        $display("FAIL window_idle step %0d got gnt=%h conf=%h en=%b addr=%h rv=%h exp 0/0/0/0003/%h",
                 k, gnt, conflict, mem_en, mem_addr, rvalid, m_rv);
      end
    end
    req = '0;
  endtask

  task automatic test_write();
    a_addr[5] = LO; a_data[5] = 32'h0000_1234; write_en = 16'h0020; req = 16'h0020;
    step();
    n_tests++;
    if (gnt !== 16'h0020 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h0000_1234 || mem_addr !== 13'd0) begin
      n_fail++;
      $display("FAIL write_port got gnt=%h en=%b we=%b wd=%h addr=%h exp 0020/1/1/00001234/0000",
               gnt, mem_en, mem_we, mem_wdata, mem_addr);
    end
    req = '0; write_en = '0;
    for (int k = 0; k < L + 4; k++) begin
      step();
      n_tests++;
      if (rvalid !== '0 || mem_we !== 1'b0 || mem_wdata !== 32'h0000_1234) begin
        n_fail++;
        $display("FAIL write_no_rvalid step %0d got rv=%h we=%b wd=%h exp 0/0/00001234", k, rvalid, mem_we, mem_wdata);
      end
    end
  endtask

  task automatic test_pipelined();
    int order[$];
    int first_c, last_c;
    for (int i = 1; i <= 3; i++) begin a_addr[i] = LO + i; a_data[i] = '0; end
    write_en = '0; req = 16'h000E; first_c = -1; last_c = -1;
    for (int k = 0; k < L + 8; k++) begin
      step();
      n_tests++;
      if (gnt !== m_gv || rvalid !== m_rv || dataM !== exp_dm()) begin
        n_fail++;
        $display("FAIL pipe_cycle %0d got gnt=%h rv=%h exp gnt=%h rv=%h", k, gnt, rvalid, m_gv, m_rv);
      end
      for (int i = 0; i < P; i++) if (rvalid[i] === 1'b1) begin
        order.push_back(i);
        if (first_c < 0) first_c = k;
        last_c = k;
      end
      if (m_gnt >= 0) req[m_gnt] = 1'b0;
    end
    n_tests++;
    if (order.size() != 3 || order[0] != 1 || order[1] != 2 || order[2] != 3 || last_c - first_c != 2) begin
      n_fail++;
      $display("FAIL pipe_order got n=%0d span=%0d exp n=3 order 1,2,3 span=2", order.size(), last_c - first_c);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step();
      n_tests++;
      if (gnt !== m_gv || conflict !== m_conf) begin
        n_fail++;
        $display("FAIL rand_arb cyc %0d got gnt=%h conf=%h exp gnt=%h conf=%h", c, gnt, conflict, m_gv, m_conf);
      end
      n_tests++;
      if (mem_en !== m_en || mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rand_port cyc %0d got en=%b we=%b addr=%h wd=%h exp %b/%b/%h/%h",
                 c, mem_en, mem_we, mem_addr, mem_wdata, m_en, m_we, m_addr, m_wdata);
      end
      n_tests++;
      if (rvalid !== m_rv || dataM !== exp_dm()) begin
        n_fail++;
        $display("FAIL rand_return cyc %0d got rv=%h exp rv=%h", c, rvalid, m_rv);
      end
      for (int i = 0; i < P; i++) begin
        if (m_gnt == i) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else begin
            a_addr[i] = int'($urandom_range(HI + 2, LO - 2));
            write_en[i] = 1'($urandom_range(1, 0));
            a_data[i] = $urandom();
          end
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          a_addr[i] = int'($urandom_range(HI + 2, LO - 2));
          write_en[i] = 1'($urandom_range(1, 0));
          a_data[i] = $urandom();
        end else if (req[i] && !in_win(a_addr[i]) && $urandom_range(7, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < P; i++) begin a_addr[i] = 0; a_data[i] = '0; end
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_window();
    test_write();
    test_pipelined();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
